// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the RAM access arbiter: FSM states, port selects
// and RAM geometry.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Port select encoding carried from the grant to the ack stage.
  localparam logic SEL_IF  = 1'b0;
  localparam logic SEL_MEM = 1'b1;

  localparam int DEPTH_DEFAULT        = 256;
  localparam int RAM_ADDR_BITS        = 8;
  localparam int STARVE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/mem_arb_prio.sv
// Grant decision between the IF and MEM ports. MEM wins ties until it has
// taken STARVE_LIMIT consecutive grants over a waiting IF, then IF is forced.
module mem_arb_prio
  import mem_ctrl_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic mem_req,
  input  logic arb_en,
  output logic grant_valid,
  output logic grant_sel
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt_q;
  logic [CW-1:0] starve_cnt_d;

  // Grant selection and next starvation count; only active while the FSM idles.
  always_comb begin
    grant_valid  = 1'b0;
    grant_sel    = SEL_IF;
    starve_cnt_d = starve_cnt_q;
    if (arb_en) begin
      if (mem_req && if_req) begin
        grant_valid = 1'b1;
        if (starve_cnt_q < LIMIT) begin
          grant_sel    = SEL_MEM;
          starve_cnt_d = starve_cnt_q + 1'b1;
        end else begin
          grant_sel    = SEL_IF;
          starve_cnt_d = '0;
        end
      end else if (mem_req) begin
        // IF is not waiting, so nothing is being starved.
        grant_valid  = 1'b1;
        grant_sel    = SEL_MEM;
        starve_cnt_d = '0;
      end else if (if_req) begin
        grant_valid  = 1'b1;
        grant_sel    = SEL_IF;
        starve_cnt_d = '0;
      end else begin
        starve_cnt_d = '0;
      end
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares one word-addressed RAM between the IF and MEM ports. Every access
// walks IDLE -> SETUP -> STROBE -> DONE so address, direction and data are
// stable before Enable rises and stay stable until after it falls.
module mem_access_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int DEPTH        = DEPTH_DEFAULT,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        mem_req,
  input  logic        mem_rw,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_ack,
  output logic [31:0] mem_rdata,
  output logic        mem_err,
  output logic        ram_en,
  output logic        ram_rw,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout,
  output logic        busy
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  state_e      state_q;
  logic        sel_q;
  logic        ram_en_q;
  logic        ram_rw_q;
  logic [31:0] ram_addr_q;
  logic [31:0] ram_din_q;
  logic        if_ack_q;
  logic        if_err_q;
  logic [31:0] if_rdata_q;
  logic        mem_ack_q;
  logic        mem_err_q;
  logic [31:0] mem_rdata_q;

  logic        grant_valid;
  logic        grant_sel;
  logic [31:0] grant_addr;
  logic        grant_legal;

  mem_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk        (clk),
    .reset      (reset),
    .if_req     (if_req),
    .mem_req    (mem_req),
    .arb_en     (state_q == IDLE),
    .grant_valid(grant_valid),
    .grant_sel  (grant_sel)
  );

  // Address of whichever port wins this cycle, and its range check.
  always_comb begin
    grant_addr  = (grant_sel == SEL_MEM) ? mem_addr : if_addr;
    grant_legal = (grant_addr < DEPTH_W);
  end

  // Access sequencer; all RAM-side and port-side outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_q       <= SEL_IF;
      ram_en_q    <= 1'b0;
      ram_rw_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      if_ack_q    <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      mem_ack_q   <= 1'b0;
      mem_err_q   <= 1'b0;
      mem_rdata_q <= '0;
    end else begin
      // Acks and errors are single-cycle pulses unless set below.
      if_ack_q  <= 1'b0;
      if_err_q  <= 1'b0;
      mem_ack_q <= 1'b0;
      mem_err_q <= 1'b0;
      ram_en_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            sel_q <= grant_sel;
            if (grant_legal) begin
              // The IF port is read-only, so its direction is forced to read.
              ram_addr_q <= grant_addr;
              ram_rw_q   <= (grant_sel == SEL_MEM) ? mem_rw : 1'b0;
              ram_din_q  <= (grant_sel == SEL_MEM) ? mem_wdata : 32'd0;
              state_q    <= SETUP;
            end else begin
              // Out-of-range: answer immediately without touching the RAM.
              if (grant_sel == SEL_MEM) begin
                mem_ack_q <= 1'b1;
                mem_err_q <= 1'b1;
              end else begin
                if_ack_q <= 1'b1;
                if_err_q <= 1'b1;
              end
              state_q <= DONE;
            end
          end
        end
        SETUP: begin
          ram_en_q <= 1'b1;
          state_q  <= STROBE;
        end
        STROBE: begin
          // Enable falls on entry to DONE; read data is captured on the same edge.
          if (sel_q == SEL_MEM) begin
            mem_ack_q <= 1'b1;
            if (!ram_rw_q) begin
              mem_rdata_q <= ram_dout;
            end
          end else begin
            if_ack_q   <= 1'b1;
            if_rdata_q <= ram_dout;
          end
          state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ram_en    = ram_en_q;
  assign ram_rw    = ram_rw_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign if_ack    = if_ack_q;
  assign if_err    = if_err_q;
  assign if_rdata  = if_rdata_q;
  assign mem_ack   = mem_ack_q;
  assign mem_err   = mem_err_q;
  assign mem_rdata = mem_rdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter with a behavioural RAM attached.
module tb_mem_access_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        mem_req = 1'b0;
  logic        mem_rw = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic        ram_en;
  logic        ram_rw;
  logic [31:0] ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic        busy;

  int total = 0;
  int bad = 0;
  int en_cnt = 0;

  logic [31:0] ram_mem [0:255];

  mem_access_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_ack   (if_ack),
    .if_rdata (if_rdata),
    .if_err   (if_err),
    .mem_req  (mem_req),
    .mem_rw   (mem_rw),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .mem_err  (mem_err),
    .ram_en   (ram_en),
    .ram_rw   (ram_rw),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: asynchronous read, write while Enable is high at a clock edge.
  assign ram_dout = ram_mem[ram_addr[7:0]];
  always @(posedge clk) begin
    if (ram_en) begin
      en_cnt <= en_cnt + 1;
      if (ram_rw) ram_mem[ram_addr[7:0]] <= ram_din;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_txn(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic err);
    mem_req = 1'b1; mem_rw = rw; mem_addr = addr; mem_wdata = wdata;
    lat = -1; err = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (mem_ack) begin
        lat = i; err = mem_err;
        break;
      end
    end
    mem_req = 1'b0;
    tick();
    $display("txn MEM rw=%0d addr=%h wdata=%h lat=%0d err=%0d rdata=%h", rw, addr, wdata, lat, err, mem_rdata);
  endtask

  task automatic if_txn(input logic [31:0] addr, output int lat, output logic err);
    if_req = 1'b1; if_addr = addr;
    lat = -1; err = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (if_ack) begin
        lat = i; err = if_err;
        break;
      end
    end
    if_req = 1'b0;
    tick();
    $display("txn IF addr=%h lat=%0d err=%0d rdata=%h", addr, lat, err, if_rdata);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    total++;
    if ({if_ack, if_err, mem_ack, mem_err, ram_en, ram_rw, busy} !== 7'd0) begin
      bad++; $display("FAIL reset_flags got %b want 0", {if_ack, if_err, mem_ack, mem_err, ram_en, ram_rw, busy});
    end
    total++;
    if ({if_rdata, mem_rdata} !== 64'd0) begin
      bad++; $display("FAIL reset_rdata got %h want 0", {if_rdata, mem_rdata});
    end
    total++;
    if ({ram_addr, ram_din} !== 64'd0) begin
      bad++; $display("FAIL reset_ram_bus got %h want 0", {ram_addr, ram_din});
    end
    reset = 1'b0;
    tick();
    $display("txn reset done");
  endtask

  task automatic test_mem_write();
    int en0;
    en0 = en_cnt;
    mem_req = 1'b1; mem_rw = 1'b1; mem_addr = 32'h10; mem_wdata = 32'hDEADBEEF;
    tick();  // grant edge -> SETUP
    total++;
    if ({busy, ram_en, ram_rw, ram_addr, ram_din, mem_ack} !== {1'b1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0}) begin
      bad++; $display("FAIL wr_setup got busy=%b en=%b rw=%b a=%h d=%h ack=%b want 1 0 1 10 deadbeef 0",
                      busy, ram_en, ram_rw, ram_addr, ram_din, mem_ack);
    end
    // Inputs move after the grant; the latched copies must keep driving the RAM.
    mem_addr = 32'h55; mem_wdata = 32'h0; mem_rw = 1'b0;
    tick();  // STROBE
    total++;
    if ({ram_en, ram_rw, ram_addr, ram_din, mem_ack} !== {1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0}) begin
      bad++; $display("FAIL wr_strobe got en=%b rw=%b a=%h d=%h ack=%b want 1 1 10 deadbeef 0",
                      ram_en, ram_rw, ram_addr, ram_din, mem_ack);
    end
    tick();  // DONE
    total++;
    if ({ram_en, ram_rw, ram_addr, ram_din, mem_ack, mem_err, if_ack} !== {1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL wr_done got en=%b rw=%b a=%h d=%h ack=%b err=%b ifack=%b want 0 1 10 deadbeef 1 0 0",
                      ram_en, ram_rw, ram_addr, ram_din, mem_ack, mem_err, if_ack);
    end
    mem_req = 1'b0;
    tick();  // IDLE
    total++;
    if ({busy, mem_ack} !== 2'b00) begin
      bad++; $display("FAIL wr_idle got busy=%b ack=%b want 0 0", busy, mem_ack);
    end
    total++;
    if (en_cnt - en0 !== 1) begin
      bad++; $display("FAIL wr_en_cycles got %0d want 1", en_cnt - en0);
    end
    total++;
    if (ram_mem[8'h10] !== 32'hDEADBEEF) begin
      bad++; $display("FAIL wr_ram_content got %h want deadbeef", ram_mem[8'h10]);
    end
    $display("txn MEM write addr=10 data=deadbeef");
  endtask

  task automatic test_readback();
    int lat;
    logic err;
    if_txn(32'h10, lat, err);
    total++;
    if (lat !== 3 || err !== 1'b0) begin
      bad++; $display("FAIL rb_lat got lat=%0d err=%b want 3 0", lat, err);
    end
    total++;
    if (if_rdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL rb_if_rdata got %h want deadbeef", if_rdata);
    end
    total++;
    if (mem_rdata !== 32'h0) begin
      bad++; $display("FAIL rb_mem_rdata_unchanged got %h want 0", mem_rdata);
    end
    total++;
    if (ram_rw !== 1'b0) begin
      bad++; $display("FAIL rb_if_rw got %b want 0", ram_rw);
    end
  endtask

  task automatic test_illegal();
    int lat;
    int en0;
    logic err;
    mem_txn(1'b0, 32'h10, 32'h0, lat, err);
    total++;
    if (mem_rdata !== 32'hDEADBEEF || lat !== 3) begin
      bad++; $display("FAIL ill_pre_read got %h lat=%0d want deadbeef 3", mem_rdata, lat);
    end
    en0 = en_cnt;
    mem_txn(1'b1, 32'h100, 32'h11111111, lat, err);
    total++;
    if (lat !== 1 || err !== 1'b1) begin
      bad++; $display("FAIL ill_mem_ack got lat=%0d err=%b want 1 1", lat, err);
    end
    total++;
    if (en_cnt - en0 !== 0) begin
      bad++; $display("FAIL ill_ram_en got %0d want 0", en_cnt - en0);
    end
    total++;
    if (mem_rdata !== 32'hDEADBEEF || mem_err !== 1'b0) begin
      bad++; $display("FAIL ill_mem_hold got rdata=%h err=%b want deadbeef 0", mem_rdata, mem_err);
    end
    if_txn(32'hFFFF_FFFF, lat, err);
    total++;
    if (lat !== 1 || err !== 1'b1 || if_rdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL ill_if got lat=%0d err=%b rdata=%h want 1 1 deadbeef", lat, err, if_rdata);
    end
    // Last legal address must be accepted.
    mem_txn(1'b1, 32'hFF, 32'h0BADCAFE, lat, err);
    total++;
    if (lat !== 3 || err !== 1'b0 || ram_mem[8'hFF] !== 32'h0BADCAFE) begin
      bad++; $display("FAIL ill_edge_ff got lat=%0d err=%b ram=%h want 3 0 0badcafe", lat, err, ram_mem[8'hFF]);
    end
  endtask

  task automatic test_contention();
    int seq [10];
    int n;
    int exp;
    n = 0;
    for (int i = 0; i < 10; i++) seq[i] = 2;
    if_req = 1'b1; if_addr = 32'h10;
    mem_req = 1'b1; mem_rw = 1'b0; mem_addr = 32'hFF;
    for (int c = 0; c < 100 && n < 10; c++) begin
      tick();
      if (if_ack && mem_ack) begin
        total++; bad++; $display("FAIL cont_double_ack at cycle %0d", c);
      end
      if (if_ack) begin
        seq[n] = 0; n++;
      end else if (mem_ack) begin
        seq[n] = 1; n++;
      end
      if (n == 10) begin
        if_req = 1'b0; mem_req = 1'b0;
      end
    end
    if_req = 1'b0; mem_req = 1'b0;
    tick();
    total++;
    if (n !== 10) begin
      bad++; $display("FAIL cont_count got %0d want 10", n);
    end
    for (int i = 0; i < 10; i++) begin
      exp = (i % 5 == 4) ? 0 : 1;
      total++;
      if (seq[i] !== exp) begin
        bad++; $display("FAIL cont_grant_%0d got %0d want %0d (1=MEM 0=IF)", i, seq[i], exp);
      end
      $display("txn contention grant %0d port=%s", i, (seq[i] == 1) ? "MEM" : "IF");
    end
  endtask

  task automatic test_reset_mid();
    mem_req = 1'b1; mem_rw = 1'b1; mem_addr = 32'h30; mem_wdata = 32'h12345678;
    tick();  // SETUP
    tick();  // STROBE
    total++;
    if (ram_en !== 1'b1) begin
      bad++; $display("FAIL rst_mid_strobe got en=%b want 1", ram_en);
    end
    reset = 1'b1; mem_req = 1'b0;
    tick();
    total++;
    if ({ram_en, busy, mem_ack, mem_err, if_ack, if_err, ram_rw} !== 7'd0) begin
      bad++; $display("FAIL rst_mid_flags got en=%b busy=%b ack=%b err=%b ifack=%b iferr=%b rw=%b want all 0",
                      ram_en, busy, mem_ack, mem_err, if_ack, if_err, ram_rw);
    end
    total++;
    if ({ram_addr, ram_din, if_rdata, mem_rdata} !== 128'd0) begin
      bad++; $display("FAIL rst_mid_data got a=%h d=%h if=%h mem=%h want 0", ram_addr, ram_din, if_rdata, mem_rdata);
    end
    // Reset together with a fresh request: reset wins, nothing is granted.
    mem_req = 1'b1; mem_rw = 1'b0; mem_addr = 32'h10;
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL rst_with_req got busy=%b want 0", busy);
    end
    mem_req = 1'b0; reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if ({mem_ack, if_ack, busy} !== 3'b000) begin
        bad++; $display("FAIL rst_no_ack cycle %0d got ack=%b ifack=%b busy=%b want 0", i, mem_ack, if_ack, busy);
      end
    end
    $display("txn reset mid-access");
  endtask

  task automatic test_back_to_back();
    int lat;
    int acks;
    logic err;
    mem_txn(1'b1, 32'h20, 32'hCAFEF00D, lat, err);
    mem_req = 1'b1; mem_rw = 1'b0; mem_addr = 32'h10;
    acks = 0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (mem_ack) begin
        lat = i;
        break;
      end
    end
    if (mem_ack) acks++;
    total++;
    if (lat !== 3 || mem_rdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL b2b_first got lat=%0d rdata=%h want 3 deadbeef", lat, mem_rdata);
    end
    $display("txn MEM read addr=10 lat=%0d rdata=%h", lat, mem_rdata);
    mem_addr = 32'h20;  // req stays high across the ack
    tick();  // IDLE
    if (mem_ack) acks++;
    total++;
    if ({busy, mem_ack} !== 2'b00) begin
      bad++; $display("FAIL b2b_idle got busy=%b ack=%b want 0 0", busy, mem_ack);
    end
    tick();  // SETUP of the second access
    if (mem_ack) acks++;
    total++;
    if (busy !== 1'b1 || ram_addr !== 32'h20) begin
      bad++; $display("FAIL b2b_regrant got busy=%b addr=%h want 1 20", busy, ram_addr);
    end
    tick();  // STROBE
    if (mem_ack) acks++;
    tick();  // DONE
    if (mem_ack) acks++;
    total++;
    if (mem_ack !== 1'b1 || mem_rdata !== 32'hCAFEF00D) begin
      bad++; $display("FAIL b2b_second got ack=%b rdata=%h want 1 cafef00d", mem_ack, mem_rdata);
    end
    $display("txn MEM read addr=20 rdata=%h", mem_rdata);
    mem_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (mem_ack) acks++;
    end
    total++;
    if (acks !== 2 || busy !== 1'b0) begin
      bad++; $display("FAIL b2b_ack_count got acks=%0d busy=%b want 2 0", acks, busy);
    end
  endtask

  initial begin
    test_reset();
    test_mem_write();
    test_readback();
    test_illegal();
    test_contention();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
